// File: rtl/count_mod_updown_pkg.sv
// -----------------------------------------------------------------------------
// count_mod_updown_pkg
// Shared constants for the up/down modulo counter family.
//   CNT_UP / CNT_DN     : values of the up_dn input selecting count direction
//   CNT_WRAP / CNT_SAT  : values of the SATURATE parameter selecting the
//                         behaviour at the ends of the count range
// -----------------------------------------------------------------------------
package count_mod_updown_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

endpackage : count_mod_updown_pkg

// File: rtl/count_prescaler.sv
// -----------------------------------------------------------------------------
// count_prescaler
// Divides the enable stream: counts enabled cycles 0..PRESCALE-1 and raises
// tick on the enabled cycle where the count sits at PRESCALE-1, after which the
// count returns to 0. Cycles with en low hold the count.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous reset, active-high (count -> 0)
//   en      in  enable; only enabled cycles advance the count
//   restart in  synchronous return of the count to 0 (counter clear/load)
//   tick    out one-cycle step strobe (combinational from count and en)
// -----------------------------------------------------------------------------
module count_prescaler #(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcount_q;
    logic [PW-1:0] pcount_d;

    // tick is deliberately not gated by restart; the counter top gives
    // clr/load priority over the step itself.
    assign tick = en & (pcount_q == LAST);

    always_comb begin
        pcount_d = pcount_q;
        if (restart) begin
            pcount_d = '0;
        end else if (en) begin
            pcount_d = (pcount_q == LAST) ? '0 : pcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

endmodule : count_prescaler

// File: rtl/count_mod_updown.sv
// -----------------------------------------------------------------------------
// count_mod_updown
// Parametrised synchronous up/down modulo-MODULUS counter with prescaled
// enable, sync clear, clamped parallel load, wrap or saturate at the range
// ends, terminal count / carry-out for cascading and a sticky overflow flag.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous reset, active-high
//   en      in  count enable (through the prescaler)
//   up_dn   in  1 = count up, 0 = count down
//   clr     in  synchronous clear to 0 (highest priority)
//   load    in  synchronous load of data (clamped to MODULUS-1)
//   data    in  load value
//   ovf_clr in  clears the sticky overflow flag
//   out     out registered count
//   tc      out terminal count for the current direction (combinational)
//   co      out carry/borrow out = tc & tick, feeds en of the next stage
//   ovf     out sticky: a step was attempted at terminal count
// -----------------------------------------------------------------------------
module count_mod_updown
    import count_mod_updown_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             co,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tick;
    logic             step;
    logic             restart;

    assign restart = clr | load;

    // With no division the prescaler is pure overhead, so en is the tick.
    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign tick = en;
        end else begin : g_prescale
            count_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .restart (restart),
                .tick    (tick)
            );
        end
    endgenerate

    always_comb begin
        tc = 1'b0;
        case (up_dn)
            CNT_UP:  tc = (out_q == MAX_VAL);
            CNT_DN:  tc = (out_q == '0);
            default: tc = 1'b0;
        endcase
    end

    assign co  = tc & tick;
    assign out = out_q;
    assign ovf = ovf_q;

    // Next count: clr beats load beats step. Loads above the range clamp to
    // the top value so out never leaves 0..MODULUS-1.
    always_comb begin
        out_d = out_q;
        step  = 1'b0;
        if (clr) begin
            out_d = '0;
        end else if (load) begin
            out_d = (data > MAX_VAL) ? MAX_VAL : data;
        end else if (tick) begin
            step = 1'b1;
            case (up_dn)
                CNT_UP: begin
                    if (out_q == MAX_VAL) begin
                        out_d = (SATURATE == CNT_WRAP) ? '0 : out_q;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end
                CNT_DN: begin
                    if (out_q == '0) begin
                        out_d = (SATURATE == CNT_SAT) ? out_q : MAX_VAL;
                    end else begin
                        out_d = out_q - 1'b1;
                    end
                end
                default: out_d = out_q;
            endcase
        end
    end

    // Sticky overflow: a real step at terminal count sets it, and a set on
    // the same edge as ovf_clr wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (step && tc) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RST_VAL;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

endmodule : count_mod_updown

// File: tb/tb_count_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_count_mod_updown
// Directed bench for count_mod_updown: a wrapping modulo-10 counter, a
// saturating one, a prescale-by-3 one and a two-stage decimal cascade, all
// sharing clock, reset and the control inputs; each section starts from reset.
// -----------------------------------------------------------------------------
module tb_count_mod_updown;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [7:0] data;
    logic       ovf_clr;

    logic       en_a, en_b, en_c, en_lo;
    logic [7:0] out_a, out_b, out_c, out_lo, out_hi;
    logic       tc_a, tc_b, tc_c, tc_lo, tc_hi;
    logic       co_a, co_b, co_c, co_lo, co_hi;
    logic       ovf_a, ovf_b, ovf_c, ovf_lo, ovf_hi;

    int tests_run  = 0;
    int fail_count = 0;
    int cur;
    int co_pulses;

    always #5 clk = ~clk;

    count_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .RESET_VAL(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en_a), .up_dn(up_dn), .clr(clr), .load(load), .data(data),
        .ovf_clr(ovf_clr), .out(out_a), .tc(tc_a), .co(co_a), .ovf(ovf_a));

    count_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .RESET_VAL(0), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_dn), .clr(clr), .load(load), .data(data),
        .ovf_clr(ovf_clr), .out(out_b), .tc(tc_b), .co(co_b), .ovf(ovf_b));

    count_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .RESET_VAL(0), .PRESCALE(3)) u_pre (
        .clk(clk), .rst(rst), .en(en_c), .up_dn(up_dn), .clr(clr), .load(load), .data(data),
        .ovf_clr(ovf_clr), .out(out_c), .tc(tc_c), .co(co_c), .ovf(ovf_c));

    count_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .RESET_VAL(0), .PRESCALE(1)) u_lo (
        .clk(clk), .rst(rst), .en(en_lo), .up_dn(up_dn), .clr(clr), .load(load), .data(data),
        .ovf_clr(ovf_clr), .out(out_lo), .tc(tc_lo), .co(co_lo), .ovf(ovf_lo));

    count_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .RESET_VAL(0), .PRESCALE(1)) u_hi (
        .clk(clk), .rst(rst), .en(co_lo), .up_dn(up_dn), .clr(clr), .load(load), .data(data),
        .ovf_clr(ovf_clr), .out(out_hi), .tc(tc_hi), .co(co_hi), .ovf(ovf_hi));

    // Drives the shared control inputs; called just after a clock edge.
    task automatic applyStimulus(input logic up, input logic c, input logic ld,
                                 input logic [7:0] d, input logic oc);
        up_dn   = up;
        clr     = c;
        load    = ld;
        data    = d;
        ovf_clr = oc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests_run++;
        assert (got === expv)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // One clock: inputs settle, edge, then sample 1 ns later.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_lo = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_lo = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        #12;
        checkOutput("reset_out", 32'(out_a), 32'd0);
        checkOutput("reset_ovf", 32'(ovf_a), 32'd0);
        checkOutput("reset_tc", 32'(tc_a), 32'd0);
        rst = 1'b0;

        // ---- wrap, count up 12 steps: 1..9,0,1,2 ; ovf after the 10th ----
        stepClock();
        en_a = 1'b1;
        cur  = 0;
        for (int i = 1; i <= 12; i++) begin
            checkOutput($sformatf("wrap_up_tc_%0d", i), 32'(tc_a), 32'(cur == 9));
            checkOutput($sformatf("wrap_up_co_%0d", i), 32'(co_a), 32'(cur == 9));
            stepClock();
            cur = (cur + 1) % 10;
            checkOutput($sformatf("wrap_up_out_%0d", i), 32'(out_a), 32'(cur));
            checkOutput($sformatf("wrap_up_ovf_%0d", i), 32'(ovf_a), 32'(i >= 10));
        end

        // ---- wrap, then down from 2: 1,0,9,8 ; co pulses once at 0 ----
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        stepClock();
        checkOutput("wrap_dn_out_first", 32'(out_a), 32'd1);
        co_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            co_pulses += int'(co_a);
            stepClock();
        end
        checkOutput("wrap_dn_out", 32'(out_a), 32'd8);
        checkOutput("wrap_dn_co_pulses", 32'(co_pulses), 32'd1);
        checkOutput("wrap_dn_ovf_sticky", 32'(ovf_a), 32'd1);

        // ---- ovf_clr with no tick clears the flag ----
        en_a = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        stepClock();
        checkOutput("ovf_clr", 32'(ovf_a), 32'd0);
        checkOutput("ovf_clr_out_hold", 32'(out_a), 32'd8);

        // ---- load clamps, clr beats load, tc follows up_dn at once ----
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd200, 1'b0);
        stepClock();
        checkOutput("load_clamp", 32'(out_a), 32'd9);
        checkOutput("load_tc_up", 32'(tc_a), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
        stepClock();
        checkOutput("clr_over_load", 32'(out_a), 32'd0);
        checkOutput("tc_up_at_0", 32'(tc_a), 32'd0);
        up_dn = 1'b0;
        #1;
        checkOutput("tc_dn_at_0", 32'(tc_a), 32'd1);
        en_a = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
        stepClock();
        checkOutput("load_over_step", 32'(out_a), 32'd7);
        checkOutput("load_keeps_ovf", 32'(ovf_a), 32'd0);

        // ---- saturate: 15 up steps hold at 9, ovf from the 10th ----
        pulseReset();
        stepClock();
        en_b = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            stepClock();
            checkOutput($sformatf("sat_up_out_%0d", i), 32'(out_b), 32'((i < 9) ? i : 9));
            checkOutput($sformatf("sat_up_ovf_%0d", i), 32'(ovf_b), 32'(i >= 10));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        stepClock();
        checkOutput("sat_set_beats_clr", 32'(ovf_b), 32'd1);
        en_b = 1'b0;
        stepClock();
        checkOutput("sat_ovf_clr", 32'(ovf_b), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        en_b = 1'b1;
        stepClock();
        checkOutput("sat_dn_hold_0", 32'(out_b), 32'd0);
        checkOutput("sat_dn_ovf", 32'(ovf_b), 32'd1);

        // ---- prescale by 3: 9 enabled cycles -> 3 steps ----
        pulseReset();
        stepClock();
        en_c = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            stepClock();
            checkOutput($sformatf("pre_out_%0d", i), 32'(out_c), 32'(i / 3));
        end

        // ---- prescale with en low for 2 cycles mid-way ----
        pulseReset();
        stepClock();
        en_c = 1'b1;
        stepClock();
        stepClock();
        checkOutput("pre_gap_before", 32'(out_c), 32'd0);
        en_c = 1'b0;
        stepClock();
        stepClock();
        checkOutput("pre_gap_hold", 32'(out_c), 32'd0);
        en_c = 1'b1;
        stepClock();
        checkOutput("pre_gap_after", 32'(out_c), 32'd1);

        // ---- two-stage decimal cascade: 25 ticks -> 2,5 ----
        pulseReset();
        stepClock();
        en_lo = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            stepClock();
            if (i == 10) begin
                checkOutput("casc_lo_10", 32'(out_lo), 32'd0);
                checkOutput("casc_hi_10", 32'(out_hi), 32'd1);
            end
        end
        checkOutput("casc_lo_25", 32'(out_lo), 32'd5);
        checkOutput("casc_hi_25", 32'(out_hi), 32'd2);

        // ---- async reset mid-count clears both stages before any edge ----
        rst = 1'b1;
        #1;
        checkOutput("casc_rst_lo", 32'(out_lo), 32'd0);
        checkOutput("casc_rst_hi", 32'(out_hi), 32'd0);
        rst = 1'b0;
        en_lo = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule : tb_count_mod_updown
